// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rdy;
    logic [DATA_W-1:0] if_data;

    logic              dm_re;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_rdy;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    logic              pipe_stall;
    logic              err_timeout;
    logic              err_proto;

    // Arbiter side
    modport master (
        input  if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata, mem_valid,
        output if_rdy, if_data, dm_rdy, dm_rdata, mem_en, mem_wr, mem_addr, mem_wdata,
               pipe_stall, err_timeout, err_proto
    );

    // Pipeline stages and memory side
    modport slave (
        output if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata, mem_valid,
        input  if_rdy, if_data, dm_rdy, dm_rdata, mem_en, mem_wr, mem_addr, mem_wdata,
               pipe_stall, err_timeout, err_proto
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port fetch/data memory arbiter and access sequencer
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MAX_DM_RUN = 4,
    parameter int TIMEOUT    = 255
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int RW = $clog2(MAX_DM_RUN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DM_RUN);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    logic [1:0]    state;
    logic          owner;
    logic [RW-1:0] run_cnt;
    logic [TW-1:0] tmo_cnt;

    logic              dm_pend;
    logic              grant_if;
    logic              grant_dm;
    logic              tmo_hit;
    logic              wait_end;
    logic [DATA_W-1:0] cap_data;

    // Grant decision: data side drains first unless a fetch has been starved for MAX_DM_RUN grants
    always_comb begin
        dm_pend  = bus.dm_re | bus.dm_we;
        grant_if = (state == S_IDLE) & bus.if_req & (~dm_pend | (run_cnt == RUN_MAX));
        grant_dm = (state == S_IDLE) & dm_pend & ~grant_if;
        tmo_hit  = (state == S_WAIT) & ~bus.mem_valid & (tmo_cnt == TMO_MAX);
        wait_end = ((state == S_WAIT) & bus.mem_valid) | tmo_hit;
        cap_data = bus.mem_valid ? bus.mem_rdata : '0;
    end

    // Stall the pipe while either stage holds a request that has not completed this cycle
    assign bus.pipe_stall = (bus.if_req & ~bus.if_rdy) | (dm_pend & ~bus.dm_rdy);

    // Sequencer state, access owner, starvation run counter and wait timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            owner   <= OWN_IF;
            run_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_if) begin
                        state   <= S_ISSUE;
                        owner   <= OWN_IF;
                        run_cnt <= '0;
                    end else if (grant_dm) begin
                        state <= S_ISSUE;
                        owner <= OWN_DM;
                        if (!bus.if_req)
                            run_cnt <= '0;
                        else if (run_cnt != RUN_MAX)
                            run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (wait_end)
                        state <= S_DONE;
                    else
                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                S_DONE: begin
                    tmo_cnt <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory request registers: loaded at grant, strobe lasts only the ISSUE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_en <= 1'b0;
            if (grant_if) begin
                bus.mem_en    <= 1'b1;
                bus.mem_wr    <= 1'b0;
                bus.mem_addr  <= bus.if_addr;
                bus.mem_wdata <= '0;
            end else if (grant_dm) begin
                bus.mem_en    <= 1'b1;
                bus.mem_wr    <= bus.dm_we;
                bus.mem_addr  <= bus.dm_addr;
                bus.mem_wdata <= bus.dm_wdata;
            end
        end
    end

    // Completion: capture read data (zero on timeout) and raise the owner's one-cycle ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.if_rdy   <= 1'b0;
            bus.dm_rdy   <= 1'b0;
            bus.if_data  <= '0;
            bus.dm_rdata <= '0;
        end else begin
            bus.if_rdy <= 1'b0;
            bus.dm_rdy <= 1'b0;
            if (wait_end) begin
                if (owner == OWN_IF) begin
                    bus.if_rdy  <= 1'b1;
                    bus.if_data <= cap_data;
                end else begin
                    bus.dm_rdy <= 1'b1;
                    if (!bus.mem_wr)
                        bus.dm_rdata <= cap_data;
                end
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err_timeout <= 1'b0;
            bus.err_proto   <= 1'b0;
        end else begin
            if (tmo_hit)
                bus.err_timeout <= 1'b1;
            if (grant_dm && bus.dm_re && bus.dm_we)
                bus.err_proto <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int MAXRUN = 4;
    localparam int TMO    = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DM_RUN(MAXRUN), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        int          cyc;
    } acc_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t if_q[$];
    rsp_t dm_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    bit mem_on = 1'b1;
    logic [15:0] last_dm = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hB123 : (a ^ 16'hA5C3);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: answers mem_en after lat cycles and checks each access against the queue
    initial begin
        int   cnt;
        acc_t e;
        cnt = 0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 16'hFFFF;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_valid = 1'b0;
            bus.mem_rdata = 16'hFFFF;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && mem_on) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_rdata = mem_fn(bus.mem_addr);
                end
            end
            if (bus.mem_en) begin
                if (acc_q.size() == 0) begin
                    check("mem_en_spurious", bus.mem_en, 0);
                end else begin
                    e = acc_q.pop_front();
                    check("acc_cyc", cyc, e.cyc);
                    check("acc_addr", bus.mem_addr, e.addr);
                    check("acc_wr", bus.mem_wr, e.wr);
                    if (e.wr)
                        check("acc_wdata", bus.mem_wdata, e.wdata);
                end
                cnt = lat;
            end
        end
    end

    // Response monitor: every ready pulse must match the next scoreboard entry
    initial begin
        rsp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (bus.if_rdy) begin
                if (if_q.size() == 0) begin
                    check("if_rdy_spurious", bus.if_rdy, 0);
                end else begin
                    r = if_q.pop_front();
                    check("if_rdy_cyc", cyc, r.cyc);
                    check("if_data", bus.if_data, r.data);
                end
            end
            if (bus.dm_rdy) begin
                if (dm_q.size() == 0) begin
                    check("dm_rdy_spurious", bus.dm_rdy, 0);
                end else begin
                    r = dm_q.pop_front();
                    check("dm_rdy_cyc", cyc, r.cyc);
                    check("dm_rdata", bus.dm_rdata, r.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rdy(input bit is_if, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (is_if ? bus.if_rdy : bus.dm_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (is_if) check("if_rdy_wait", ok, 1);
        else       check("dm_rdy_wait", ok, 1);
    endtask

    task automatic push_acc(input logic [15:0] a, input logic wr, input logic [15:0] wd, input int c);
        acc_t e;
        e.addr = a; e.wr = wr; e.wdata = wd; e.cyc = c;
        acc_q.push_back(e);
    endtask

    task automatic push_if(input logic [15:0] d, input int c);
        rsp_t r;
        r.data = d; r.cyc = c;
        if_q.push_back(r);
    endtask

    task automatic push_dm(input logic [15:0] d, input int c);
        rsp_t r;
        r.data = d; r.cyc = c;
        dm_q.push_back(r);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"}, bus.mem_en, 0);
        check({tag, "_mem_wr"}, bus.mem_wr, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_if_rdy"}, bus.if_rdy, 0);
        check({tag, "_dm_rdy"}, bus.dm_rdy, 0);
        check({tag, "_if_data"}, bus.if_data, 0);
        check({tag, "_dm_rdata"}, bus.dm_rdata, 0);
        check({tag, "_err_timeout"}, bus.err_timeout, 0);
        check({tag, "_err_proto"}, bus.err_proto, 0);
        check({tag, "_pipe_stall"}, bus.pipe_stall, 0);
    endtask

    // Simple fetch with lat = L starting in the current cycle
    task automatic fetch(input logic [15:0] a, input int l);
        int t0;
        lat = l;
        step();
        t0 = cyc;
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        push_acc(a, 1'b0, 16'h0, t0 + 1);
        push_if(mem_fn(a), t0 + 2 + l);
        wait_rdy(1'b1, 40);
        bus.if_req = 1'b0;
    endtask

    task automatic starve_run();
        int t0;
        lat = 1;
        step();
        t0 = cyc;
        bus.dm_re   = 1'b1;
        bus.dm_addr = 16'h0300;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0400;
        for (int k = 0; k < MAXRUN; k++) begin
            push_acc(16'h0300, 1'b0, 16'h0, t0 + 1 + 4 * k);
            push_dm(mem_fn(16'h0300), t0 + 3 + 4 * k);
        end
        push_acc(16'h0400, 1'b0, 16'h0, t0 + 1 + 4 * MAXRUN);
        push_if(mem_fn(16'h0400), t0 + 3 + 4 * MAXRUN);
        last_dm = mem_fn(16'h0300);
        for (int k = 0; k < MAXRUN; k++)
            wait_rdy(1'b0, 40);
        wait_rdy(1'b1, 40);
        bus.dm_re  = 1'b0;
        bus.if_req = 1'b0;
    endtask

    initial begin
        int t0;
        rst_n        = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_re    = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;

        step();
        step();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fetch-only, L = 1, with stall profile
        lat = 1;
        step();
        t0 = cyc;
        bus.if_addr = 16'h0010;
        bus.if_req  = 1'b1;
        push_acc(16'h0010, 1'b0, 16'h0, t0 + 1);
        push_if(16'hB123, t0 + 3);
        #1 check("stall_c0", bus.pipe_stall, 1);
        step();
        check("stall_c1", bus.pipe_stall, 1);
        step();
        check("stall_c2", bus.pipe_stall, 1);
        wait_rdy(1'b1, 40);
        check("stall_done", bus.pipe_stall, 0);
        bus.if_req = 1'b0;
        step();
        step();
        check("if_data_hold", bus.if_data, 16'hB123);

        // Load and fetch together, L = 2: data first
        lat = 2;
        step();
        t0 = cyc;
        bus.dm_re   = 1'b1;
        bus.dm_addr = 16'h0200;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0100;
        push_acc(16'h0200, 1'b0, 16'h0, t0 + 1);
        push_acc(16'h0100, 1'b0, 16'h0, t0 + 6);
        push_dm(mem_fn(16'h0200), t0 + 4);
        push_if(mem_fn(16'h0100), t0 + 9);
        last_dm = mem_fn(16'h0200);
        wait_rdy(1'b0, 40);
        bus.dm_re = 1'b0;
        wait_rdy(1'b1, 40);
        bus.if_req = 1'b0;

        // Starvation, twice: second run shows the counter returned to zero
        starve_run();
        starve_run();

        // Store: write data presented, dm_rdata unchanged
        lat = 1;
        step();
        t0 = cyc;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 16'h0033;
        bus.dm_wdata = 16'h5A5A;
        push_acc(16'h0033, 1'b1, 16'h5A5A, t0 + 1);
        push_dm(last_dm, t0 + 3);
        wait_rdy(1'b0, 40);
        bus.dm_we = 1'b0;
        step();
        check("err_proto_clean", bus.err_proto, 0);

        // Read and write together: treated as write, protocol error flagged
        step();
        t0 = cyc;
        bus.dm_re    = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 16'h0044;
        bus.dm_wdata = 16'h1234;
        push_acc(16'h0044, 1'b1, 16'h1234, t0 + 1);
        push_dm(last_dm, t0 + 3);
        wait_rdy(1'b0, 40);
        bus.dm_re = 1'b0;
        bus.dm_we = 1'b0;
        step();
        check("err_proto_set", bus.err_proto, 1);

        // Timeout: memory silent, ready TIMEOUT+2 cycles after ISSUE with zero data
        mem_on = 1'b0;
        step();
        t0 = cyc;
        bus.if_addr = 16'h0055;
        bus.if_req  = 1'b1;
        push_acc(16'h0055, 1'b0, 16'h0, t0 + 1);
        push_if(16'h0000, t0 + 1 + TMO + 2);
        check("err_timeout_pre", bus.err_timeout, 0);
        wait_rdy(1'b1, 40);
        bus.if_req = 1'b0;
        mem_on = 1'b1;
        step();
        check("err_timeout_set", bus.err_timeout, 1);
        fetch(16'h0010, 1);
        step();
        check("err_timeout_sticky", bus.err_timeout, 1);

        // Reset asserted in WAIT, late mem_valid afterwards must be ignored
        lat = 5;
        step();
        t0 = cyc;
        bus.if_addr = 16'h0066;
        bus.if_req  = 1'b1;
        push_acc(16'h0066, 1'b0, 16'h0, t0 + 1);
        step();
        step();
        step();
        rst_n = 1'b0;
        bus.if_req = 1'b0;
        #1 check_all_zero("mid_rst");
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_idle", bus.mem_en, 0);
        end
        fetch(16'h0077, 1);
        step();
        check("post_rst_err", bus.err_timeout, 0);

        step();
        step();
        check("acc_q_left", acc_q.size(), 0);
        check("if_q_left", if_q.size(), 0);
        check("dm_q_left", dm_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
